// File: rtl/controle_sirene.sv
// controle_sirene -- alarm panel controller.
//
// Takes keypad digits, checks the 4-digit arm/disarm code, runs the exit and
// entry delays, times the siren and locks the keypad out after repeated wrong
// codes. It drives ENABLE back into the sensor logic that produces A.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         synchronous active-low reset
//   A             alarm request from the sensor logic (level)
//   digito        keypad digit: 0-9 digit, F clear, A-E ignored
//   digito_valido one-cycle strobe qualifying digito
//   ENABLE        arm enable to the sensor logic
//   SIRENE        siren drive
//   armado        armed LED (also lit during the exit delay)
//   alerta        entry-delay buzzer
//   bloqueado     keypad lockout active
module controle_sirene #(
  parameter int          EXIT_DELAY   = 16,
  parameter int          ENTRY_DELAY  = 8,
  parameter int          SIREN_TIME   = 32,
  parameter logic [15:0] CODIGO       = 16'h1234,
  parameter int          MAX_ERROS    = 3,
  parameter int          LOCKOUT_TIME = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       A,
  input  logic [3:0] digito,
  input  logic       digito_valido,
  output logic       ENABLE,
  output logic       SIRENE,
  output logic       armado,
  output logic       alerta,
  output logic       bloqueado
);

  localparam int M1   = (EXIT_DELAY > ENTRY_DELAY) ? EXIT_DELAY : ENTRY_DELAY;
  localparam int M2   = (M1 > SIREN_TIME) ? M1 : SIREN_TIME;
  localparam int MAXD = (M2 > LOCKOUT_TIME) ? M2 : LOCKOUT_TIME;
  localparam int TW   = $clog2(MAXD) + 1;
  localparam int EW   = $clog2(MAX_ERROS + 1);

  localparam logic [TW-1:0] T_EXIT  = TW'(EXIT_DELAY);
  localparam logic [TW-1:0] T_ENTRY = TW'(ENTRY_DELAY);
  localparam logic [TW-1:0] T_SIREN = TW'(SIREN_TIME);
  localparam logic [TW-1:0] T_LOCK  = TW'(LOCKOUT_TIME);
  localparam logic [EW-1:0] E_LAST  = EW'(MAX_ERROS - 1);

  typedef enum logic [2:0] {
    DESARMADO = 3'd0,
    SAIDA     = 3'd1,
    ARMADO    = 3'd2,
    ENTRADA   = 3'd3,
    DISPARO   = 3'd4
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [TW-1:0] lock_q, lock_d;
  logic [EW-1:0] err_q, err_d;
  logic [15:0]   buf_q, buf_d;
  logic [1:0]    cnt_q, cnt_d;
  // Code verdict from the 4th digit, applied one edge later.
  logic          ok_q, ok_d;
  logic          bad_q, bad_d;

  // Keypad: digit buffer and code comparison.
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    ok_d  = 1'b0;
    bad_d = 1'b0;
    if (lock_q != '0) begin
      buf_d = '0;
      cnt_d = '0;
    end else if (digito_valido) begin
      if (digito <= 4'd9) begin
        if (cnt_q == 2'd3) begin
          ok_d  = ({buf_q[11:0], digito} == CODIGO);
          bad_d = ~ok_d;
          buf_d = '0;
          cnt_d = '0;
        end else begin
          buf_d = {buf_q[11:0], digito};
          cnt_d = cnt_q + 2'd1;
        end
      end else if (digito == 4'hF) begin
        buf_d = '0;
        cnt_d = '0;
      end
    end
  end

  // State machine, error counter and lockout timer. A code verdict wins
  // over any timer expiry or A event in the same cycle. A timer reaching 1
  // means this is the last cycle in the state, so each delay lasts exactly
  // its load value in cycles. A is used directly: it is a level and is
  // sampled only while armed, so a one-edge skew is harmless.
  always_comb begin
    estado_d = estado_q;
    tmr_d    = tmr_q;
    err_d    = err_q;
    lock_d   = (lock_q != '0) ? lock_q - 1'b1 : '0;
    if (ok_q) begin
      err_d = '0;
      if (estado_q == DESARMADO) begin
        estado_d = SAIDA;
        tmr_d    = T_EXIT;
      end else begin
        estado_d = DESARMADO;
        tmr_d    = '0;
      end
    end else if (bad_q) begin
      if (err_q == E_LAST) begin
        err_d  = '0;
        lock_d = T_LOCK;
      end else begin
        err_d = err_q + 1'b1;
      end
    end else begin
      case (estado_q)
        DESARMADO: ;
        SAIDA: begin
          if (tmr_q <= 1) begin
            estado_d = ARMADO;
            tmr_d    = '0;
          end else tmr_d = tmr_q - 1'b1;
        end
        ARMADO: begin
          if (A) begin
            estado_d = ENTRADA;
            tmr_d    = T_ENTRY;
          end
        end
        ENTRADA: begin
          if (tmr_q <= 1) begin
            estado_d = DISPARO;
            tmr_d    = T_SIREN;
          end else tmr_d = tmr_q - 1'b1;
        end
        DISPARO: begin
          if (tmr_q <= 1) begin
            estado_d = ARMADO;
            tmr_d    = '0;
          end else tmr_d = tmr_q - 1'b1;
        end
        default: begin
          estado_d = DESARMADO;
          tmr_d    = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same
  // edge as the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q  <= DESARMADO;
      tmr_q     <= '0;
      lock_q    <= '0;
      err_q     <= '0;
      buf_q     <= '0;
      cnt_q     <= '0;
      ok_q      <= 1'b0;
      bad_q     <= 1'b0;
      ENABLE    <= 1'b0;
      SIRENE    <= 1'b0;
      armado    <= 1'b0;
      alerta    <= 1'b0;
      bloqueado <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      tmr_q     <= tmr_d;
      lock_q    <= lock_d;
      err_q     <= err_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      ok_q      <= ok_d;
      bad_q     <= bad_d;
      ENABLE    <= (estado_d inside {ARMADO, ENTRADA, DISPARO});
      armado    <= (estado_d inside {SAIDA, ARMADO, ENTRADA, DISPARO});
      alerta    <= (estado_d == ENTRADA);
      SIRENE    <= (estado_d == DISPARO);
      bloqueado <= (lock_d != '0);
    end
  end

endmodule

// File: tb/tb_controle_sirene.sv
// Testbench for controle_sirene: directed scenarios with randomized gaps and
// A noise, plus a random soak, all shadowed by a cycle reference model.
module tb_controle_sirene;

  localparam int EXIT_DELAY   = 16;
  localparam int ENTRY_DELAY  = 8;
  localparam int SIREN_TIME   = 32;
  localparam int CODE         = 'h1234;
  localparam int MAX_ERROS    = 3;
  localparam int LOCKOUT_TIME = 16;

  // Model modes.
  localparam int M_OFF = 0, M_EXIT = 1, M_ARM = 2, M_ENTRY = 3, M_SIREN = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       A = 1'b0;
  logic [3:0] digito = 4'd0;
  logic       dv = 1'b0;
  logic       ENABLE, SIRENE, armado, alerta, bloqueado;

  int nc = 0;
  int nf = 0;
  bit chk_en = 1'b0;

  controle_sirene dut (
    .clk(clk), .rst_n(rst_n), .A(A), .digito(digito), .digito_valido(dv),
    .ENABLE(ENABLE), .SIRENE(SIRENE), .armado(armado), .alerta(alerta),
    .bloqueado(bloqueado)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_mode = 0, m_rem = 0, m_nd = 0, m_val = 0, m_pend = 0, m_err = 0, m_lock = 0;

  always @(posedge clk) begin : ref_model
    int mode, rem, nd, val, pend, npend, err, lk;
    mode = m_mode; rem = m_rem; nd = m_nd; val = m_val;
    err = m_err; lk = m_lock; npend = 0; pend = m_pend;
    if (!rst_n) begin
      mode = M_OFF; rem = 0; nd = 0; val = 0; err = 0; lk = 0; pend = 0;
    end else begin
      if (m_lock == 0 && dv) begin
        if (digito <= 9) begin
          val = val * 16 + int'(digito);
          nd++;
          if (nd == 4) begin
            npend = (val == CODE) ? 1 : 2;
            nd = 0; val = 0;
          end
        end else if (digito == 4'hF) begin
          nd = 0; val = 0;
        end
      end
      if (m_lock != 0) begin nd = 0; val = 0; end
      if (lk > 0) lk--;
      if (pend == 1) begin
        err = 0;
        if (mode == M_OFF) begin mode = M_EXIT; rem = EXIT_DELAY; end
        else begin mode = M_OFF; rem = 0; end
      end else if (pend == 2) begin
        err++;
        if (err == MAX_ERROS) begin err = 0; lk = LOCKOUT_TIME; end
      end else begin
        case (mode)
          M_EXIT:  begin rem--; if (rem == 0) mode = M_ARM; end
          M_ARM:   if (A) begin mode = M_ENTRY; rem = ENTRY_DELAY; end
          M_ENTRY: begin rem--; if (rem == 0) begin mode = M_SIREN; rem = SIREN_TIME; end end
          M_SIREN: begin rem--; if (rem == 0) mode = M_ARM; end
          default: ;
        endcase
      end
    end
    m_mode <= mode; m_rem <= rem; m_nd <= nd; m_val <= val;
    m_pend <= (rst_n ? npend : 0); m_err <= err; m_lock <= lk;
  end

  // Every-cycle scoreboard against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [4:0] exp_o, got_o;
      exp_o = {m_mode >= M_ARM, m_mode >= M_EXIT, m_mode == M_ENTRY,
               m_mode == M_SIREN, m_lock != 0};
      got_o = {ENABLE, armado, alerta, SIRENE, bloqueado};
      nc++;
      if (got_o !== exp_o) begin
        nf++;
        $display("FAIL model_cycle t=%0t {EN,arm,alr,sir,blq} got=%b exp=%b", $time, got_o, exp_o);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic a, input logic v, input logic [3:0] d);
    A = a; dv = v; digito = d;
    @(negedge clk);
  endtask

  task automatic enter_code(input logic [15:0] c, input int maxgap);
    for (int i = 3; i >= 0; i--) begin
      cyc(1'b0, 1'b1, c[i*4 +: 4]);
      if (i > 0) repeat ($urandom_range(maxgap, 0)) cyc(1'b0, 1'b0, 4'($urandom));
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 4'($urandom_range(9, 0)));
      nc++;
      if ({ENABLE, armado, alerta, SIRENE, bloqueado} !== 5'b0) begin
        nf++; $display("FAIL reset_outputs got=%b exp=00000", {ENABLE, armado, alerta, SIRENE, bloqueado});
      end
    end
    rst_n = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 4'd0);
      nc++;
      if ({ENABLE, armado} !== 2'b00) begin
        nf++; $display("FAIL disarmed_ignores_A got=%b exp=00", {ENABLE, armado});
      end
    end
  endtask

  task automatic test_arming;
    int cnt;
    enter_code(16'h1234, 3);
    nc++;
    if (armado !== 1'b0) begin nf++; $display("FAIL arm_not_early got=%b exp=0", armado); end
    cyc(1'($urandom), 1'b0, 4'd0);
    nc++;
    if ({armado, ENABLE} !== 2'b10) begin
      nf++; $display("FAIL arm_exit_start got=%b exp=10", {armado, ENABLE});
    end
    cnt = 1;
    for (int k = 0; k < 100; k++) begin
      cyc(1'($urandom), 1'b0, 4'd0);
      if (ENABLE) break;
      cnt++;
    end
    nc++;
    if (cnt != EXIT_DELAY) begin nf++; $display("FAIL exit_delay_len got=%0d exp=%0d", cnt, EXIT_DELAY); end
    cyc(1'b0, 1'b0, 4'd0);
    nc++;
    if ({ENABLE, armado, alerta} !== 3'b110) begin
      nf++; $display("FAIL armed_state got=%b exp=110", {ENABLE, armado, alerta});
    end
  endtask

  task automatic test_trigger;
    int cnt;
    cyc(1'b1, 1'b0, 4'd0);
    nc++;
    if ({alerta, ENABLE} !== 2'b11) begin nf++; $display("FAIL entry_start got=%b exp=11", {alerta, ENABLE}); end
    cnt = 1;
    for (int k = 0; k < 50; k++) begin
      cyc(1'($urandom), 1'b0, 4'd0);
      if (!alerta) break;
      cnt++;
    end
    nc++;
    if (cnt != ENTRY_DELAY) begin nf++; $display("FAIL entry_delay_len got=%0d exp=%0d", cnt, ENTRY_DELAY); end
    nc++;
    if (SIRENE !== 1'b1) begin nf++; $display("FAIL siren_start got=%b exp=1", SIRENE); end
    cnt = 1;
    for (int k = 0; k < 100; k++) begin
      cyc(1'b0, 1'b0, 4'd0);
      if (!SIRENE) break;
      cnt++;
    end
    nc++;
    if (cnt != SIREN_TIME) begin nf++; $display("FAIL siren_len got=%0d exp=%0d", cnt, SIREN_TIME); end
    nc++;
    if ({ENABLE, armado, alerta, SIRENE} !== 4'b1100) begin
      nf++; $display("FAIL siren_return got=%b exp=1100", {ENABLE, armado, alerta, SIRENE});
    end
  endtask

  task automatic test_disarm_siren;
    cyc(1'b1, 1'b0, 4'd0);
    repeat (ENTRY_DELAY) cyc(1'b0, 1'b0, 4'd0);
    nc++;
    if (SIRENE !== 1'b1) begin nf++; $display("FAIL disarm_pre_siren got=%b exp=1", SIRENE); end
    enter_code(16'h1234, 2);
    nc++;
    if (SIRENE !== 1'b1) begin nf++; $display("FAIL disarm_siren_hold got=%b exp=1", SIRENE); end
    cyc(1'b0, 1'b0, 4'd0);
    nc++;
    if ({SIRENE, ENABLE, armado} !== 3'b000) begin
      nf++; $display("FAIL disarm_siren got=%b exp=000", {SIRENE, ENABLE, armado});
    end
  endtask

  task automatic test_lockout;
    int cnt;
    logic [3:0] seq [7];
    seq = '{4'h1, 4'h2, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4};
    for (int r = 0; r < MAX_ERROS; r++) enter_code(16'h9999, 2);
    nc++;
    if (bloqueado !== 1'b0) begin nf++; $display("FAIL lock_not_early got=%b exp=0", bloqueado); end
    cyc(1'b0, 1'b0, 4'd0);
    nc++;
    if (bloqueado !== 1'b1) begin nf++; $display("FAIL lock_start got=%b exp=1", bloqueado); end
    cnt = 1;
    for (int k = 0; k < 60; k++) begin
      if (k < 4) cyc(1'b0, 1'b1, 4'(k + 1));
      else cyc(1'b0, 1'b0, 4'd0);
      if (!bloqueado) break;
      cnt++;
    end
    nc++;
    if (cnt != LOCKOUT_TIME) begin nf++; $display("FAIL lock_len got=%0d exp=%0d", cnt, LOCKOUT_TIME); end
    repeat (2) cyc(1'b0, 1'b0, 4'd0);
    nc++;
    if (armado !== 1'b0) begin nf++; $display("FAIL lock_code_ignored got=%b exp=0", armado); end
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 1'b1, seq[i]);
      repeat ($urandom_range(2, 0)) cyc(1'b0, 1'b0, 4'd0);
    end
    cyc(1'b0, 1'b0, 4'd0);
    nc++;
    if (armado !== 1'b1) begin nf++; $display("FAIL clear_then_arm got=%b exp=1", armado); end
    for (int k = 0; k < 40 && !ENABLE; k++) cyc(1'b0, 1'b0, 4'd0);
    nc++;
    if (ENABLE !== 1'b1) begin nf++; $display("FAIL rearm_timeout got=%b exp=1", ENABLE); end
  endtask

  task automatic test_corner_entry;
    bit sir_seen;
    cyc(1'b1, 1'b0, 4'd0);
    for (int k = 1; k <= 7; k++) begin
      if (k >= 4) cyc(1'($urandom), 1'b1, 4'(k - 3));
      else cyc(1'($urandom), 1'b0, 4'd0);
    end
    nc++;
    if (alerta !== 1'b1) begin nf++; $display("FAIL corner_still_entry got=%b exp=1", alerta); end
    cyc(1'b0, 1'b0, 4'd0);
    nc++;
    if ({ENABLE, armado, alerta, SIRENE} !== 4'b0000) begin
      nf++; $display("FAIL corner_disarm got=%b exp=0000", {ENABLE, armado, alerta, SIRENE});
    end
    sir_seen = 1'b0;
    repeat (40) begin
      cyc(1'($urandom), 1'b0, 4'd0);
      if (SIRENE) sir_seen = 1'b1;
    end
    nc++;
    if (sir_seen) begin nf++; $display("FAIL corner_no_siren got=1 exp=0"); end
  endtask

  task automatic test_reset_mid;
    enter_code(16'h1234, 1);
    for (int k = 0; k < 40 && !ENABLE; k++) cyc(1'b0, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 4'd0);
    repeat (ENTRY_DELAY + 3) cyc(1'b0, 1'b0, 4'd0);
    nc++;
    if (SIRENE !== 1'b1) begin nf++; $display("FAIL rstmid_pre got=%b exp=1", SIRENE); end
    rst_n = 1'b0;
    cyc(1'b1, 1'b0, 4'd0);
    nc++;
    if ({ENABLE, armado, alerta, SIRENE, bloqueado} !== 5'b0) begin
      nf++; $display("FAIL rstmid_outputs got=%b exp=00000", {ENABLE, armado, alerta, SIRENE, bloqueado});
    end
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 4'd0);
    nc++;
    if ({ENABLE, SIRENE} !== 2'b00) begin nf++; $display("FAIL rstmid_after got=%b exp=00", {ENABLE, SIRENE}); end
  endtask

  task automatic test_random;
    int idx;
    idx = 0;
    for (int n = 0; n < 1500; n++) begin
      logic a;
      a = ($urandom_range(15, 0) == 0);
      if ($urandom_range(3, 0) == 0) begin
        if ($urandom_range(9, 0) < 7) begin
          cyc(a, 1'b1, 4'(idx + 1));
          idx = (idx + 1) % 4;
        end else begin
          cyc(a, 1'b1, 4'($urandom));
        end
      end else begin
        cyc(a, 1'b0, 4'($urandom));
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_arming();
    test_trigger();
    test_disarm_siren();
    test_lockout();
    test_corner_entry();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end

endmodule

// File: doc/controle_sirene.md
Name: controle_sirene

Overview:
- Consumer end of the alarm-trigger line: receives the combinational alarm request A from the sensor logic and drives that logic's ENABLE input.
- Owns the arm/disarm keypad sequence, exit and entry delays, timed siren activation and the wrong-code lockout.
- Sits between the keypad decoder and the siren driver in the residential security top level.

Parameters:
- EXIT_DELAY, 16: cycles from valid arming code until the system is armed.
- ENTRY_DELAY, 8: cycles from an alarm request until the siren fires, if not disarmed.
- SIREN_TIME, 32: cycles the siren stays on per trigger.
- CODIGO, 16'h1234: 4-digit BCD secret; first digit in [15:12].
- MAX_ERROS, 3: consecutive wrong codes that cause lockout.
- LOCKOUT_TIME, 16: cycles keypad input is ignored after lockout.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst_n, input, 1: synchronous active-low reset.
- A, input, 1: alarm request from the sensor logic; level, asynchronous to keypad.
- digito, input, 4: keypad digit 0-9; 4'hF = clear entry; 4'hA-4'hE ignored.
- digito_valido, input, 1: one-cycle strobe qualifying digito.
- ENABLE, output, 1: arm enable to the sensor logic.
- SIRENE, output, 1: siren drive.
- armado, output, 1: armed indicator (LED).
- alerta, output, 1: entry-delay warning (buzzer).
- bloqueado, output, 1: keypad lockout active.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=DESARMADO; all outputs 0.
  - Digit buffer, digit count, error count and all timers cleared.
  - Applies mid-operation from any state, including DISPARO and lockout.
- States: DESARMADO, SAIDA, ARMADO, ENTRADA, DISPARO.
- Outputs are registered, decoded from the state:
  - ENABLE=1 in ARMADO, ENTRADA, DISPARO.
  - armado=1 in SAIDA, ARMADO, ENTRADA, DISPARO.
  - alerta=1 in ENTRADA only.
  - SIRENE=1 in DISPARO only.
  - bloqueado=1 while the lockout timer is nonzero.
- Digit entry (when bloqueado=0):
  - A strobe with digito 0-9 shifts the digit into a 16-bit buffer (left shift 4) and increments the count.
  - 4'hF clears the buffer and count; 4'hA-4'hE have no effect.
  - On the 4th digit the buffer is compared with CODIGO, then buffer and count are cleared.
  - The result acts on the next edge: strobe at edge N gives a state change visible after edge N+1.
- Code correct:
  - Error count is cleared.
  - DESARMADO goes to SAIDA and loads the timer with EXIT_DELAY.
  - SAIDA, ARMADO, ENTRADA or DISPARO go to DESARMADO; SIRENE drops in the same cycle the state changes.
- Code wrong:
  - Error count increments; state is unchanged.
  - When the count reaches MAX_ERROS: error count is cleared, lockout timer loads LOCKOUT_TIME, bloqueado=1 from the next cycle.
- Lockout:
  - Strobes are ignored while locked out; the buffer is held cleared.
  - The timer decrements each cycle; bloqueado falls when it reaches 0.
  - The state machine keeps running during lockout; the alarm can still fire.
- SAIDA:
  - Timer decrements each cycle; at 0 the state goes to ARMADO.
  - A is ignored in this state.
- ARMADO: A=1 sampled on an edge moves the state to ENTRADA and loads ENTRY_DELAY.
- ENTRADA:
  - Timer decrements each cycle; at 0 the state goes to DISPARO and loads SIREN_TIME.
  - A returning to 0 does not cancel the delay; only a correct code does.
- DISPARO:
  - SIRENE=1 for exactly SIREN_TIME cycles, then the state returns to ARMADO.
  - If A is still 1 on return, the next edge re-enters ENTRADA.
- Simultaneous events: a code decision has priority over a timer expiry or an A event in the same cycle.
  - Example: a correct code on the cycle ENTRADA's timer hits 0 gives DESARMADO, not DISPARO.
- Timers: width is $clog2 of the largest delay +1. Each delay is measured as the exact number of cycles spent in the state.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles, with A=1 and strobes active -> all outputs 0, state DESARMADO; A has no effect while disarmed.
- Arming sequence: enter 1,2,3,4 -> armado=1 after edge N+1 while ENABLE=0; ENABLE=1 exactly EXIT_DELAY=16 cycles later; pulse A during SAIDA -> ignored.
- Trigger and timeout: armed, then A=1 for 1 cycle -> alerta=1 for 8 cycles; then SIRENE=1 for 32 cycles; then ARMADO with SIRENE=0 and ENABLE=1.
- Disarm during siren: enter 1,2,3,4 during DISPARO -> SIRENE=0 and ENABLE=0 one cycle after the 4th strobe.
- Lockout:
  - Enter 9,9,9,9 three times -> bloqueado=1 for 16 cycles.
  - A correct code entered during lockout is ignored.
  - After lockout the correct code arms normally.
  - Enter 1,2,F,1,2,3,4 -> clear works; the system arms.
- Corner cases:
  - Correct code on the cycle ENTRADA's timer expires -> DESARMADO, SIRENE never 1.
  - rst_n=0 mid-DISPARO -> SIRENE=0 next edge.
